// File: rtl/scroll_pkg.sv
// Shared constants and helpers for the scrolling 7-segment message driver.
// Holds character codes, active-low segment patterns and the window index function.
package scroll_pkg;

    // 3-bit character codes
    localparam logic [2:0] CH_H     = 3'd0;
    localparam logic [2:0] CH_E     = 3'd1;
    localparam logic [2:0] CH_L     = 3'd2;
    localparam logic [2:0] CH_O     = 3'd3;
    localparam logic [2:0] CH_A     = 3'd4;
    localparam logic [2:0] CH_P     = 3'd5;
    localparam logic [2:0] CH_Y     = 3'd6;
    localparam logic [2:0] CH_BLANK = 3'd7;

    // Active-low segment patterns, bit 0 = segment a ... bit 6 = segment g
    localparam logic [6:0] SEG_H     = 7'b0001001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_L     = 7'b1000111;
    localparam logic [6:0] SEG_O     = 7'b1000000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_P     = 7'b0001100;
    localparam logic [6:0] SEG_Y     = 7'b0010001;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // (base + off) mod len for base < len. The off % len term folds to a
    // constant at every call site, so only one compare/subtract is built.
    function automatic int unsigned wrap_idx(
        input int unsigned base,
        input int unsigned off,
        input int unsigned len
    );
        int unsigned s;
        s = base + (off % len);
        if (s >= len) s = s - len;
        return s;
    endfunction

endpackage

// File: rtl/char_seg_decoder.sv
// Combinational decoder from a 3-bit character code to an active-low 7-segment pattern.
// Ports: code (in, 3) character code; seg (out, 7) segments, bit 0 = a .. bit 6 = g.
module char_seg_decoder
    import scroll_pkg::*;
(
    input  logic [2:0] code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        unique case (code)
            CH_H:     seg = SEG_H;
            CH_E:     seg = SEG_E;
            CH_L:     seg = SEG_L;
            CH_O:     seg = SEG_O;
            CH_A:     seg = SEG_A;
            CH_P:     seg = SEG_P;
            CH_Y:     seg = SEG_Y;
            CH_BLANK: seg = SEG_BLANK;
            default:  seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/scroll_char_display.sv
// Scrolling message driver: shows a NUM_DISP-wide window of a loaded message on
// active-low 7-segment displays, advancing on a divided tick or a manual step.
// Ports: clk, reset (sync, active high), msg_in (3*MSG_LEN), load, enable, step,
//        dir (only with SCROLL_DIR_EN: 0 left, 1 right),
//        hex (7*NUM_DISP, registered), head (index of leftmost char), tick (pulse).
// Optional feature macro: SCROLL_DIR_EN adds the dir input for right scrolling.
module scroll_char_display
    import scroll_pkg::*;
#(
    parameter int NUM_DISP = 5,
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 50000000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [3*MSG_LEN-1:0]       msg_in,
    input  logic                       load,
    input  logic                       enable,
    input  logic                       step,
`ifdef SCROLL_DIR_EN
    input  logic                       dir,
`endif
    output logic [7*NUM_DISP-1:0]      hex,
    output logic [$clog2(MSG_LEN)-1:0] head,
    output logic                       tick
);

    localparam int HW = $clog2(MSG_LEN);
    localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST  = DW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HEAD_LAST = HW'(MSG_LEN - 1);

    logic [2:0]    msg [MSG_LEN];
    logic [DW-1:0] div;
    logic          wrap;
    logic          adv;
    logic [HW-1:0] head_next;

    // With TICK_DIV=1 the divider is a constant 0 and wrap equals enable.
    assign wrap = enable && (div == DIV_LAST);
    assign adv  = wrap || step;

`ifdef SCROLL_DIR_EN
    always_comb begin
        head_next = head;
        if (dir) begin
            head_next = (head == '0) ? HEAD_LAST : head - 1'b1;
        end else begin
            head_next = (head == HEAD_LAST) ? '0 : head + 1'b1;
        end
    end
`else
    always_comb begin
        head_next = (head == HEAD_LAST) ? '0 : head + 1'b1;
    end
`endif

    // Load wins over step and wrap: no advance and no tick on a load edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < MSG_LEN; i++) msg[i] <= CH_BLANK;
            head <= '0;
            div  <= '0;
            tick <= 1'b0;
        end else if (load) begin
            for (int i = 0; i < MSG_LEN; i++) msg[i] <= msg_in[3*i +: 3];
            head <= '0;
            div  <= '0;
            tick <= 1'b0;
        end else begin
            if (enable) begin
                div <= wrap ? '0 : div + 1'b1;
            end
            tick <= wrap;
            if (adv) begin
                head <= head_next;
            end
        end
    end

    // Window: display k (k=0 rightmost) shows message[(head + NUM_DISP-1-k) mod MSG_LEN].
    logic [HW-1:0] idx      [NUM_DISP];
    logic [2:0]    code     [NUM_DISP];
    logic [6:0]    seg_pat  [NUM_DISP];

    for (genvar k = 0; k < NUM_DISP; k++) begin : g_disp
        assign idx[k]  = HW'(wrap_idx(32'(head), NUM_DISP - 1 - k, MSG_LEN));
        assign code[k] = msg[idx[k]];

        char_seg_decoder u_dec (
            .code (code[k]),
            .seg  (seg_pat[k])
        );
    end

    // Registered so hex trails head/message changes by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            hex <= '1;
        end else begin
            for (int k = 0; k < NUM_DISP; k++) hex[7*k +: 7] <= seg_pat[k];
        end
    end

endmodule

// File: tb/tb_scroll_char_display.sv
// Scoreboard bench for scroll_char_display: the driver queues expected outputs,
// a negedge monitor pops and compares them against the DUT instances.
module tb_scroll_char_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: 5 displays, 8 chars, TICK_DIV=4
    logic        rst_a = 1'b0, load_a = 1'b0, en_a = 1'b0, step_a = 1'b0;
    logic [23:0] msg_a = '0;
    logic [34:0] hex_a;
    logic [2:0]  head_a;
    logic        tick_a;

    // DUT B: 6 displays, 4 chars, TICK_DIV=1
    logic        rst_b = 1'b0, load_b = 1'b0, en_b = 1'b0, step_b = 1'b0;
    logic [11:0] msg_b = '0;
    logic [41:0] hex_b;
    logic [1:0]  head_b;
    logic        tick_b;

    scroll_char_display #(.NUM_DISP(5), .MSG_LEN(8), .TICK_DIV(4)) u_a (
        .clk    (clk),
        .reset  (rst_a),
        .msg_in (msg_a),
        .load   (load_a),
        .enable (en_a),
        .step   (step_a),
`ifdef SCROLL_DIR_EN
        .dir    (1'b0),
`endif
        .hex    (hex_a),
        .head   (head_a),
        .tick   (tick_a)
    );

    scroll_char_display #(.NUM_DISP(6), .MSG_LEN(4), .TICK_DIV(1)) u_b (
        .clk    (clk),
        .reset  (rst_b),
        .msg_in (msg_b),
        .load   (load_b),
        .enable (en_b),
        .step   (step_b),
`ifdef SCROLL_DIR_EN
        .dir    (1'b0),
`endif
        .hex    (hex_b),
        .head   (head_b),
        .tick   (tick_b)
    );

`ifdef SCROLL_DIR_EN
    // DUT C: 5 displays, 8 chars, TICK_DIV=1, direction control
    logic        rst_c = 1'b0, load_c = 1'b0, en_c = 1'b0, step_c = 1'b0;
    logic        dir_c = 1'b0;
    logic [23:0] msg_c = '0;
    logic [34:0] hex_c;
    logic [2:0]  head_c;
    logic        tick_c;

    scroll_char_display #(.NUM_DISP(5), .MSG_LEN(8), .TICK_DIV(1)) u_c (
        .clk    (clk),
        .reset  (rst_c),
        .msg_in (msg_c),
        .load   (load_c),
        .enable (en_c),
        .step   (step_c),
        .dir    (dir_c),
        .hex    (hex_c),
        .head   (head_c),
        .tick   (tick_c)
    );
`endif

    typedef struct {
        int          sel;
        string       name;
        logic [41:0] hex;
        int          head;
        logic        tick;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    typedef int msg8_t [8];

    msg8_t HELLO = '{0, 1, 2, 2, 3, 7, 7, 7};
    msg8_t PLAY  = '{5, 2, 4, 6, 7, 7, 7, 7};
    msg8_t BLANK = '{7, 7, 7, 7, 7, 7, 7, 7};
    msg8_t HAPY  = '{0, 4, 5, 6, 0, 0, 0, 0};

    // Segment table written a..g as listed; reversed so bit 0 = a.
    function automatic logic [6:0] seg(input int c);
        logic [6:0] ag;
        logic [6:0] r;
        case (c)
            0:       ag = 7'b1001000;
            1:       ag = 7'b0110000;
            2:       ag = 7'b1110001;
            3:       ag = 7'b0000001;
            4:       ag = 7'b0001000;
            5:       ag = 7'b0011000;
            6:       ag = 7'b1000100;
            default: ag = 7'b1111111;
        endcase
        for (int i = 0; i < 7; i++) r[i] = ag[6-i];
        return r;
    endfunction

    function automatic logic [41:0] win(input msg8_t m, input int h,
                                        input int nd, input int ml);
        logic [41:0] r;
        r = '0;
        for (int k = 0; k < nd; k++) r[7*k +: 7] = seg(m[(h + nd - 1 - k) % ml]);
        return r;
    endfunction

    function automatic logic [23:0] pack8(input msg8_t m);
        logic [23:0] r;
        for (int i = 0; i < 8; i++) r[3*i +: 3] = 3'(m[i]);
        return r;
    endfunction

    function automatic logic [11:0] pack4(input msg8_t m);
        logic [11:0] r;
        for (int i = 0; i < 4; i++) r[3*i +: 3] = 3'(m[i]);
        return r;
    endfunction

    // Drive one edge on the selected DUT, then queue the expected post-edge outputs.
    task automatic cyc(input int sel, input logic r, input logic ld,
                       input logic en, input logic st, input logic dr,
                       input int eh, input logic et,
                       input logic [41:0] ex, input string nm);
        case (sel)
            0: begin rst_a = r; load_a = ld; en_a = en; step_a = st; end
            1: begin rst_b = r; load_b = ld; en_b = en; step_b = st; end
`ifdef SCROLL_DIR_EN
            2: begin
                rst_c = r; load_c = ld; en_c = en; step_c = st; dir_c = dr;
            end
`endif
            default: ;
        endcase
        if (dr) begin end
        @(posedge clk);
        #1;
        q.push_back('{sel, nm, ex, eh, et});
    endtask

    // Monitor: compare whatever is queued against the outputs at the falling edge.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [41:0] ah;
            int          hd;
            logic        tk;
            e  = q.pop_front();
            ah = '0;
            hd = -1;
            tk = 1'bx;
            case (e.sel)
                0: begin ah = {7'b0, hex_a}; hd = int'(head_a); tk = tick_a; end
                1: begin ah = hex_b; hd = int'(head_b); tk = tick_b; end
`ifdef SCROLL_DIR_EN
                2: begin ah = {7'b0, hex_c}; hd = int'(head_c); tk = tick_c; end
`endif
                default: ;
            endcase
            tests++;
            if (ah !== e.hex || hd != e.head || tk !== e.tick) begin
                fails++;
                $display("FAIL %s: got hex=%h head=%0d tick=%b, want hex=%h head=%0d tick=%b",
                         e.name, ah, hd, tk, e.hex, e.head, e.tick);
            end
        end
    end

    initial begin
        logic [41:0] ones_a;
        logic [41:0] ones_b;
        logic [41:0] ex;
        int          hh;

        ones_a = win(BLANK, 0, 5, 8);
        ones_b = win(BLANK, 0, 6, 4);

        // Reset and idle hold
        msg_a = pack8(HELLO);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, ones_a, "rst_0");
        cyc(0, 1, 0, 0, 0, 0, 0, 0, ones_a, "rst_1");
        for (int i = 0; i < 20; i++)
            cyc(0, 0, 0, 0, 0, 0, 0, 0, ones_a, "idle_hold");

        // Load HELLO and scroll one full lap at TICK_DIV=4
        cyc(0, 0, 1, 1, 0, 0, 0, 0, ones_a, "load_hello");
        for (int n = 1; n <= 32; n++) begin
            hh = ((n - 1) / 4) % 8;
            ex = win(HELLO, hh, 5, 8);
            if (hh == 6)
                ex = {7'b0, seg(7), seg(7), seg(0), seg(1), seg(2)};
            cyc(0, 0, 0, 1, 0, 0, (n / 4) % 8, (n % 4) == 0, ex, "scroll");
        end

        // Manual steps with enable low
        cyc(0, 0, 0, 0, 1, 0, 1, 0, win(HELLO, 0, 5, 8), "step_1");
        cyc(0, 0, 0, 0, 0, 0, 1, 0, win(HELLO, 1, 5, 8), "step_1_idle");
        cyc(0, 0, 0, 0, 1, 0, 2, 0, win(HELLO, 1, 5, 8), "step_2");
        cyc(0, 0, 0, 0, 0, 0, 2, 0, win(HELLO, 2, 5, 8), "step_2_idle");
        cyc(0, 0, 0, 0, 1, 0, 3, 0, win(HELLO, 2, 5, 8), "step_3");
        ex = win(HELLO, 3, 5, 8);
        ex[34:28] = seg(2);
        cyc(0, 0, 0, 0, 0, 0, 3, 0, ex, "step_3_left_L");

        // Divider untouched by steps: first tick exactly 4 enabled cycles later
        for (int n = 1; n <= 3; n++)
            cyc(0, 0, 0, 1, 0, 0, 3, 0, win(HELLO, 3, 5, 8), "div_kept");
        cyc(0, 0, 0, 1, 0, 0, 4, 1, win(HELLO, 3, 5, 8), "div_kept_tick");

        // Step on the wrap cycle advances once
        for (int n = 5; n <= 7; n++)
            cyc(0, 0, 0, 1, 0, 0, 4, 0, win(HELLO, 4, 5, 8), "pre_wrap_step");
        cyc(0, 0, 0, 1, 1, 0, 5, 1, win(HELLO, 4, 5, 8), "wrap_and_step");

        // Load on the wrap cycle: no advance, no tick
        for (int n = 9; n <= 11; n++)
            cyc(0, 0, 0, 1, 0, 0, 5, 0, win(HELLO, 5, 5, 8), "pre_wrap_load");
        msg_a = pack8(PLAY);
        cyc(0, 0, 1, 1, 0, 0, 0, 0, win(HELLO, 5, 5, 8), "wrap_and_load");
        cyc(0, 0, 0, 1, 0, 0, 0, 0, win(PLAY, 0, 5, 8), "play_show");

        // Load mid-count clears the divider
        cyc(0, 0, 1, 1, 0, 0, 0, 0, win(PLAY, 0, 5, 8), "load_mid");
        for (int n = 1; n <= 3; n++)
            cyc(0, 0, 0, 1, 0, 0, 0, 0, win(PLAY, 0, 5, 8), "div_cleared");
        cyc(0, 0, 0, 1, 0, 0, 1, 1, win(PLAY, 0, 5, 8), "div_cleared_tick");

        // Reset beats load and step
        msg_a = pack8(HELLO);
        cyc(0, 1, 1, 1, 1, 0, 0, 0, ones_a, "rst_with_load");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, ones_a, "msg_blanked");

        // DUT B: six displays over a four-char message
        msg_b = pack4(HAPY);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, ones_b, "b_rst");
        cyc(1, 0, 1, 0, 0, 0, 0, 0, ones_b, "b_load");
        ex = {seg(0), seg(4), seg(5), seg(6), seg(0), seg(4)};
        cyc(1, 0, 0, 0, 0, 0, 0, 0, ex, "b_hapy_repeat");
        cyc(1, 0, 0, 1, 0, 0, 1, 1, win(HAPY, 0, 6, 4), "b_tick_1");
        cyc(1, 0, 0, 1, 0, 0, 2, 1, win(HAPY, 1, 6, 4), "b_tick_2");
        cyc(1, 0, 0, 1, 0, 0, 3, 1, win(HAPY, 2, 6, 4), "b_tick_3");
        cyc(1, 0, 0, 1, 0, 0, 0, 1, win(HAPY, 3, 6, 4), "b_head_wrap");
        cyc(1, 0, 0, 1, 1, 0, 1, 1, win(HAPY, 0, 6, 4), "b_step_on_tick");
        cyc(1, 0, 0, 0, 0, 0, 1, 0, win(HAPY, 1, 6, 4), "b_stop");

`ifdef SCROLL_DIR_EN
        // Right scroll from head 0, then reverse mid-run
        msg_c = pack8(HELLO);
        cyc(2, 1, 0, 0, 0, 0, 0, 0, ones_a, "c_rst");
        cyc(2, 0, 1, 0, 0, 0, 0, 0, ones_a, "c_load");
        cyc(2, 0, 0, 1, 0, 1, 7, 1, win(HELLO, 0, 5, 8), "c_right_7");
        cyc(2, 0, 0, 1, 0, 1, 6, 1, win(HELLO, 7, 5, 8), "c_right_6");
        cyc(2, 0, 0, 1, 0, 1, 5, 1, win(HELLO, 6, 5, 8), "c_right_5");
        cyc(2, 0, 0, 1, 0, 0, 6, 1, win(HELLO, 5, 5, 8), "c_left_6");
        cyc(2, 0, 0, 1, 0, 0, 7, 1, win(HELLO, 6, 5, 8), "c_left_7");
        cyc(2, 0, 0, 0, 1, 1, 6, 0, win(HELLO, 7, 5, 8), "c_step_right");
`endif

        @(negedge clk);
        #1;
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
